// File: rtl/datapath_unit_pkg.sv
// Shared types and constants for the execution datapath: ALU opcodes,
// write-back select encodings and default widths.
package datapath_unit_pkg;

  localparam int WIDTH_DEF    = 16;
  localparam int D_ADDR_W_DEF = 8;
  localparam int R_ADDR_W_DEF = 4;

  localparam logic RF_S_MEM = 1'b0;
  localparam logic RF_S_ALU = 1'b1;

  typedef enum logic [3:0] {
    ALU_PASS = 4'd0,
    ALU_ADD  = 4'd1,
    ALU_SUB  = 4'd2,
    ALU_AND  = 4'd3,
    ALU_OR   = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_NOT  = 4'd6,
    ALU_SHL  = 4'd7,
    ALU_SHR  = 4'd8,
    ALU_INC  = 4'd9,
    ALU_DEC  = 4'd10
  } alu_op_e;

endpackage

// File: rtl/datapath_unit_if.sv
// Controller-to-datapath bus: decoded strobes flow master->slave,
// debug results (ALU, write-back, flags) flow back.
interface datapath_unit_if
  import datapath_unit_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int D_ADDR_W = D_ADDR_W_DEF,
  parameter int R_ADDR_W = R_ADDR_W_DEF
) ();

  logic                D_wr;
  logic                RF_s;
  logic                RF_W_en;
  logic [D_ADDR_W-1:0] D_addr;
  logic [R_ADDR_W-1:0] RF_W_addr;
  logic [R_ADDR_W-1:0] RF_A_addr;
  logic [R_ADDR_W-1:0] RF_B_addr;
  logic [3:0]          ALU_sel;
  logic [WIDTH-1:0]    ALU_Out;
  logic [WIDTH-1:0]    WB_data;
  logic [2:0]          Flags;

  modport master (
    output D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel,
    input  ALU_Out, WB_data, Flags
  );

  modport slave (
    input  D_wr, RF_s, RF_W_en, D_addr, RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel,
    output ALU_Out, WB_data, Flags
  );

endinterface

// File: rtl/datapath_unit_reg_file.sv
// 2-read / 1-write register file. Reads are asynchronous, so a same-cycle
// read of the register being written still sees the old contents.
module datapath_unit_reg_file
  import datapath_unit_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int R_ADDR_W = R_ADDR_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [R_ADDR_W-1:0] w_addr,
  input  logic [WIDTH-1:0]    w_data,
  input  logic [R_ADDR_W-1:0] a_addr,
  input  logic [R_ADDR_W-1:0] b_addr,
  output logic [WIDTH-1:0]    ra,
  output logic [WIDTH-1:0]    rb
);

  localparam int NREGS = 2 ** R_ADDR_W;

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[w_addr] = w_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign ra = regs_q[a_addr];
  assign rb = regs_q[b_addr];

endmodule

// File: rtl/datapath_unit.sv
// Execution datapath: register file, ALU, synchronous data memory,
// write-back mux and the {N,Z,C} status register.
module datapath_unit
  import datapath_unit_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int D_ADDR_W = D_ADDR_W_DEF,
  parameter int R_ADDR_W = R_ADDR_W_DEF
) (
  input  logic            clk,
  input  logic            reset,
  datapath_unit_if.slave  bus
);

  logic [WIDTH-1:0] ra, rb;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic [WIDTH:0]   alu_ext;
  logic [WIDTH-1:0] mem_q;
  logic [WIDTH-1:0] wb_data;
  logic [2:0]       flags_d, flags_q;
  logic [WIDTH-1:0] mem [2 ** D_ADDR_W];

  datapath_unit_reg_file #(
    .WIDTH    (WIDTH),
    .R_ADDR_W (R_ADDR_W)
  ) u_reg_file (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.RF_W_en),
    .w_addr (bus.RF_W_addr),
    .w_data (wb_data),
    .a_addr (bus.RF_A_addr),
    .b_addr (bus.RF_B_addr),
    .ra     (ra),
    .rb     (rb)
  );

  // Every op produces a WIDTH+1 word whose top bit is the carry/borrow/shifted-out bit.
  always_comb begin
    alu_ext = '0;
    case (bus.ALU_sel)
      ALU_PASS: alu_ext = {1'b0, ra};
      ALU_ADD:  alu_ext = {1'b0, ra} + {1'b0, rb};
      ALU_SUB:  alu_ext = {1'b0, ra} - {1'b0, rb};
      ALU_AND:  alu_ext = {1'b0, ra & rb};
      ALU_OR:   alu_ext = {1'b0, ra | rb};
      ALU_XOR:  alu_ext = {1'b0, ra ^ rb};
      ALU_NOT:  alu_ext = {1'b0, ~ra};
      ALU_SHL:  alu_ext = {ra, 1'b0};
      ALU_SHR:  alu_ext = {ra[0], 1'b0, ra[WIDTH-1:1]};
      ALU_INC:  alu_ext = {1'b0, ra} + (WIDTH+1)'(1);
      ALU_DEC:  alu_ext = {1'b0, ra} - (WIDTH+1)'(1);
      default:  alu_ext = '0;
    endcase
    alu_result = alu_ext[WIDTH-1:0];
    alu_carry  = alu_ext[WIDTH];
  end

  assign wb_data = (bus.RF_s == RF_S_ALU) ? alu_result : mem_q;

  // Flags track ALU write-backs only; loads leave them alone.
  always_comb begin
    flags_d = flags_q;
    if (bus.RF_W_en && bus.RF_s == RF_S_ALU)
      flags_d = {alu_result[WIDTH-1], alu_result == '0, alu_carry};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) flags_q <= '0;
    else        flags_q <= flags_d;
  end

  // Block RAM style: no reset, registered read returns pre-write data.
  always_ff @(posedge clk) begin
    if (bus.D_wr) mem[bus.D_addr] <= ra;
    mem_q <= mem[bus.D_addr];
  end

  assign bus.ALU_Out = alu_result;
  assign bus.WB_data = wb_data;
  assign bus.Flags   = flags_q;

endmodule

// File: tb/tb_datapath_unit.sv
// Directed self-checking bench for datapath_unit; registers are built up
// from R0 with shift/increment sequences since there is no backdoor load.
module tb_datapath_unit;
  import datapath_unit_pkg::*;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  datapath_unit_if #(.WIDTH(16), .D_ADDR_W(8), .R_ADDR_W(4)) bus ();

  datapath_unit #(.WIDTH(16), .D_ADDR_W(8), .R_ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic wr, input logic s, input logic we,
                       input logic [7:0] da, input logic [3:0] wa,
                       input logic [3:0] aa, input logic [3:0] ba,
                       input logic [3:0] sel);
    bus.D_wr      = wr;
    bus.RF_s      = s;
    bus.RF_W_en   = we;
    bus.D_addr    = da;
    bus.RF_W_addr = wa;
    bus.RF_A_addr = aa;
    bus.RF_B_addr = ba;
    bus.ALU_sel   = sel;
  endtask

  task automatic op_cycle(input logic wr, input logic s, input logic we,
                          input logic [7:0] da, input logic [3:0] wa,
                          input logic [3:0] aa, input logic [3:0] ba,
                          input logic [3:0] sel);
    drive(wr, s, we, da, wa, aa, ba, sel);
    @(negedge clk);
  endtask

  // Builds an arbitrary constant MSB first: clear from R0, then shift/increment.
  task automatic load_const(input logic [3:0] r, input logic [15:0] val);
    op_cycle(0, 1, 1, 8'h00, r, 4'd0, 4'd0, ALU_PASS);
    for (int i = 15; i >= 0; i--) begin
      op_cycle(0, 1, 1, 8'h00, r, r, 4'd0, ALU_SHL);
      if (val[i]) op_cycle(0, 1, 1, 8'h00, r, r, 4'd0, ALU_INC);
    end
    drive(0, 1, 0, 8'h00, 4'd0, r, 4'd0, ALU_PASS);
  endtask

  task automatic test_reset;
    load_const(4'd3, 16'h1234);
    #1;
    tests_run++;
    if (bus.ALU_Out !== 16'h1234) begin
      tests_failed++;
      $display("[TB] FAIL reset_pre_r3: got %h expected %h", bus.ALU_Out, 16'h1234);
    end
    op_cycle(0, 1, 1, 8'h00, 4'd15, 4'd0, 4'd0, ALU_DEC);
    drive(0, 1, 0, 8'h00, 4'd0, 4'd3, 4'd0, ALU_PASS);
    #1;
    tests_run++;
    if (bus.Flags !== 3'b101) begin
      tests_failed++;
      $display("[TB] FAIL reset_pre_flags: got %b expected %b", bus.Flags, 3'b101);
    end
    reset = 1'b0;
    #1;
    tests_run++;
    if (bus.Flags !== 3'b000) begin
      tests_failed++;
      $display("[TB] FAIL reset_flags: got %b expected %b", bus.Flags, 3'b000);
    end
    tests_run++;
    if (bus.ALU_Out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_r3: got %h expected %h", bus.ALU_Out, 16'h0000);
    end
    bus.RF_A_addr = 4'd15;
    #1;
    tests_run++;
    if (bus.ALU_Out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL reset_r15: got %h expected %h", bus.ALU_Out, 16'h0000);
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add_sub;
    op_cycle(0, 1, 1, 8'h00, 4'd1, 4'd0, 4'd0, ALU_DEC);
    op_cycle(0, 1, 1, 8'h00, 4'd2, 4'd0, 4'd0, ALU_INC);
    drive(0, 1, 1, 8'h00, 4'd4, 4'd1, 4'd2, ALU_ADD);
    #1;
    tests_run++;
    if (bus.ALU_Out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL add_result: got %h expected %h", bus.ALU_Out, 16'h0000);
    end
    @(negedge clk);
    drive(0, 1, 0, 8'h00, 4'd0, 4'd4, 4'd0, ALU_PASS);
    #1;
    tests_run++;
    if (bus.Flags !== 3'b011) begin
      tests_failed++;
      $display("[TB] FAIL add_flags: got %b expected %b", bus.Flags, 3'b011);
    end
    tests_run++;
    if (bus.ALU_Out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL add_r4: got %h expected %h", bus.ALU_Out, 16'h0000);
    end
    drive(0, 1, 1, 8'h00, 4'd7, 4'd2, 4'd1, ALU_SUB);
    #1;
    tests_run++;
    if (bus.ALU_Out !== 16'h0002) begin
      tests_failed++;
      $display("[TB] FAIL sub_result: got %h expected %h", bus.ALU_Out, 16'h0002);
    end
    @(negedge clk);
    tests_run++;
    if (bus.Flags !== 3'b001) begin
      tests_failed++;
      $display("[TB] FAIL sub_flags: got %b expected %b", bus.Flags, 3'b001);
    end
  endtask

  task automatic test_store_load;
    load_const(4'd1, 16'hBEEF);
    op_cycle(1, 0, 0, 8'h20, 4'd0, 4'd1, 4'd0, ALU_PASS);
    op_cycle(0, 0, 0, 8'h20, 4'd0, 4'd0, 4'd0, ALU_PASS);
    drive(0, 0, 1, 8'h20, 4'd5, 4'd0, 4'd0, ALU_PASS);
    #1;
    tests_run++;
    if (bus.WB_data !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL load_wb: got %h expected %h", bus.WB_data, 16'hBEEF);
    end
    @(negedge clk);
    drive(0, 1, 0, 8'h00, 4'd0, 4'd5, 4'd0, ALU_PASS);
    #1;
    tests_run++;
    if (bus.ALU_Out !== 16'hBEEF) begin
      tests_failed++;
      $display("[TB] FAIL load_r5: got %h expected %h", bus.ALU_Out, 16'hBEEF);
    end
    tests_run++;
    if (bus.Flags !== 3'b100) begin
      tests_failed++;
      $display("[TB] FAIL load_flags: got %b expected %b", bus.Flags, 3'b100);
    end
  endtask

  task automatic test_mem_rdw;
    op_cycle(1, 0, 0, 8'h10, 4'd0, 4'd0, 4'd0, ALU_PASS);
    load_const(4'd8, 16'h5555);
    op_cycle(1, 0, 0, 8'h10, 4'd0, 4'd8, 4'd0, ALU_PASS);
    drive(0, 0, 0, 8'h10, 4'd0, 4'd0, 4'd0, ALU_PASS);
    #1;
    tests_run++;
    if (bus.WB_data !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL rdw_old: got %h expected %h", bus.WB_data, 16'h0000);
    end
    @(negedge clk);
    #1;
    tests_run++;
    if (bus.WB_data !== 16'h5555) begin
      tests_failed++;
      $display("[TB] FAIL rdw_new: got %h expected %h", bus.WB_data, 16'h5555);
    end
  endtask

  task automatic test_rf_bypass;
    load_const(4'd9, 16'h00AA);
    op_cycle(1, 0, 0, 8'h30, 4'd0, 4'd9, 4'd0, ALU_PASS);
    op_cycle(0, 0, 0, 8'h30, 4'd0, 4'd0, 4'd0, ALU_PASS);
    drive(0, 0, 1, 8'h30, 4'd6, 4'd6, 4'd0, ALU_PASS);
    #1;
    tests_run++;
    if (bus.ALU_Out !== 16'h0000) begin
      tests_failed++;
      $display("[TB] FAIL bypass_old: got %h expected %h", bus.ALU_Out, 16'h0000);
    end
    @(negedge clk);
    drive(0, 1, 0, 8'h00, 4'd0, 4'd6, 4'd0, ALU_PASS);
    #1;
    tests_run++;
    if (bus.ALU_Out !== 16'h00AA) begin
      tests_failed++;
      $display("[TB] FAIL bypass_new: got %h expected %h", bus.ALU_Out, 16'h00AA);
    end
  endtask

  task automatic test_alu_sweep;
    logic [15:0] exp_res [16];
    logic [2:0]  exp_flg [16];
    exp_res = '{16'h8001, 16'h8002, 16'h8000, 16'h0001, 16'h8001, 16'h8000,
                16'h7FFE, 16'h0002, 16'h4000, 16'h8002, 16'h8000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    exp_flg = '{3'b100, 3'b100, 3'b100, 3'b000, 3'b100, 3'b100,
                3'b000, 3'b001, 3'b001, 3'b100, 3'b100,
                3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    load_const(4'd10, 16'h8001);
    for (int sel = 0; sel < 16; sel++) begin
      drive(0, 1, 1, 8'h00, 4'd11, 4'd10, 4'd2, 4'(sel));
      #1;
      tests_run++;
      if (bus.ALU_Out !== exp_res[sel]) begin
        tests_failed++;
        $display("[TB] FAIL alu_sel%0d_result: got %h expected %h", sel, bus.ALU_Out, exp_res[sel]);
      end
      @(negedge clk);
      tests_run++;
      if (bus.Flags !== exp_flg[sel]) begin
        tests_failed++;
        $display("[TB] FAIL alu_sel%0d_flags: got %b expected %b", sel, bus.Flags, exp_flg[sel]);
      end
    end
    drive(0, 1, 0, 8'h00, 4'd0, 4'd0, 4'd0, ALU_PASS);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    drive(0, 1, 0, 8'h00, 4'd0, 4'd0, 4'd0, ALU_PASS);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_add_sub();
    test_store_load();
    test_mem_rdw();
    test_rf_bypass();
    test_alu_sweep();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
